// File: rtl/key_addition_sequencer.sv
// Sequences ROUNDS key-addition rounds through an external primary/duplicate
// KeyAddition pair, evolving the round key each round and trapping on any disagreement.
module key_addition_sequencer #(
    parameter int ROUNDS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_start,
    input  logic [3:0] io_state_in,
    input  logic [3:0] io_key_in,
    output logic [3:0] io_ka_state,
    output logic [3:0] io_ka_key,
    input  logic [3:0] io_ka_out,
    input  logic [3:0] io_ka_out_dup,
    output logic       io_busy,
    output logic       io_done,
    output logic [3:0] io_out,
    output logic       io_fault
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE, ALARM} state_t;

    localparam logic [3:0] LAST_RC = 4'(ROUNDS - 1);

    state_t     state, state_nxt;
    logic [3:0] st_reg;
    logic [3:0] rk_reg;
    logic [3:0] rc;
    logic [3:0] rc_inc;
    logic [3:0] out_reg;
    logic       mismatch;
    logic       last_round;

    assign mismatch   = io_ka_out != io_ka_out_dup;
    assign last_round = rc == LAST_RC;
    assign rc_inc     = rc + 4'd1;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (io_start) state_nxt = ROUND;
            ROUND: begin
                if (mismatch)        state_nxt = ALARM;
                else if (last_round) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            ALARM:   state_nxt = ALARM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_reg  <= 4'd0;
            rk_reg  <= 4'd0;
            rc      <= 4'd0;
            out_reg <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (io_start) begin
                        st_reg <= io_state_in;
                        rk_reg <= io_key_in;
                        rc     <= 4'd0;
                    end
                end
                ROUND: begin
                    // A mismatch freezes the datapath; only the output is cleared.
                    if (mismatch) begin
                        out_reg <= 4'd0;
                    end else begin
                        st_reg <= io_ka_out;
                        rk_reg <= {rk_reg[2:0], rk_reg[3]} ^ rc_inc;
                        if (last_round) begin
                            rc      <= 4'd0;
                            out_reg <= io_ka_out;
                        end else begin
                            rc <= rc_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_ka_state = st_reg;
    assign io_ka_key   = rk_reg;
    assign io_out      = out_reg;
    assign io_busy     = (state == ROUND) || (state == DONE);
    assign io_done     = state == DONE;
    assign io_fault    = state == ALARM;

endmodule

// File: tb/tb_key_addition_sequencer.sv
// Randomized scoreboard bench for key_addition_sequencer (ROUNDS=4) plus a
// directed ROUNDS=1 instance; the reference model works round by round in plain arithmetic.
module tb_key_addition_sequencer;

    localparam int R = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // ROUNDS=4 instance
    logic       start = 1'b0;
    logic [3:0] state_in = 4'd0, key_in = 4'd0;
    logic [3:0] ka_state, ka_key, ka_out, ka_dup, out;
    logic       busy, done, fault;
    int         inj_edge = 0;

    assign ka_out = ka_state ^ ka_key;
    assign ka_dup = ka_out ^ {3'b000, (inj_edge != 0) && (edge_cnt + 1 == inj_edge)};

    key_addition_sequencer #(.ROUNDS(R)) dut (
        .clock(clock), .reset(reset), .io_start(start),
        .io_state_in(state_in), .io_key_in(key_in),
        .io_ka_state(ka_state), .io_ka_key(ka_key),
        .io_ka_out(ka_out), .io_ka_out_dup(ka_dup),
        .io_busy(busy), .io_done(done), .io_out(out), .io_fault(fault)
    );

    // ROUNDS=1 instance
    logic       b_start = 1'b0;
    logic [3:0] b_state_in = 4'd0, b_key_in = 4'd0;
    logic [3:0] b_ka_state, b_ka_key, b_ka_out, b_out;
    logic       b_busy, b_done, b_fault;

    assign b_ka_out = b_ka_state ^ b_ka_key;

    key_addition_sequencer #(.ROUNDS(1)) dut_r1 (
        .clock(clock), .reset(reset), .io_start(b_start),
        .io_state_in(b_state_in), .io_key_in(b_key_in),
        .io_ka_state(b_ka_state), .io_ka_key(b_ka_key),
        .io_ka_out(b_ka_out), .io_ka_out_dup(b_ka_out),
        .io_busy(b_busy), .io_done(b_done), .io_out(b_out), .io_fault(b_fault)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // {state, key} after n key-addition rounds starting from (s, k).
    function automatic logic [7:0] after(input logic [3:0] s, input logic [3:0] k, input int n);
        logic [3:0] st = s;
        logic [3:0] rk = k;
        for (int i = 0; i < n; i++) begin
            st = st ^ rk;
            rk = {rk[2:0], rk[3]} ^ 4'(i + 1);
        end
        return {st, rk};
    endfunction

    typedef struct {
        int         edge_n;
        logic [3:0] value;
    } exp_t;

    exp_t       exp_q[$];
    int         op_t = -100;
    logic [3:0] op_s = 4'd0, op_k = 4'd0;
    int         alarm_edge = 0;
    logic [3:0] last_out = 4'd0;

    // Drive one cycle of stimulus; the model decides whether the start is accepted.
    task automatic cycle(input logic st, input logic [3:0] s, input logic [3:0] k);
        int         e;
        logic [7:0] res;
        @(negedge clock);
        start    = st;
        state_in = s;
        key_in   = k;
        e = edge_cnt + 1;
        if (st && alarm_edge == 0 && e > op_t + R + 1) begin
            op_t = e;
            op_s = s;
            op_k = k;
            res  = after(s, k, R);
            exp_q.push_back('{e + R, res[7:4]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", out, 0);
        check("rst_fault", fault, 0);
        check("rst_ka_state", ka_state, 0);
        check("rst_ka_key", ka_key, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_b_out", b_out, 0);
        exp_q.delete();
        op_t       = -100;
        alarm_edge = 0;
        inj_edge   = 0;
        last_out   = 4'd0;
        start      = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: compares every DUT output against the model each cycle.
    always @(negedge clock) begin
        int         k;
        bit         exp_alarm, exp_busy, exp_done;
        logic [7:0] ops;
        if (!reset) begin
            k         = edge_cnt;
            exp_alarm = alarm_edge != 0 && k >= alarm_edge;
            exp_busy  = !exp_alarm && k >= op_t && k <= op_t + R;
            exp_done  = exp_q.size() > 0 && exp_q[0].edge_n == k;
            check("fault", fault, exp_alarm);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (exp_done) begin
                check("out_done", out, exp_q[0].value);
                last_out = exp_q[0].value;
                void'(exp_q.pop_front());
            end else if (exp_alarm) begin
                check("out_alarm", out, 0);
            end else if (!exp_busy) begin
                check("out_hold", out, last_out);
            end
            if (exp_busy && k < op_t + R) begin
                ops = after(op_s, op_k, k - op_t);
                check("ka_state", ka_state, ops[7:4]);
                check("ka_key", ka_key, ops[3:0]);
            end
        end
    end

    initial begin
        logic [3:0] s, k;
        logic [7:0] res;
        #1;
        do_reset();

        // Reference vectors: 0/1 -> D, A/5 -> 8.
        cycle(1'b1, 4'h0, 4'h1);
        idle(R + 3);
        cycle(1'b1, 4'hA, 4'h5);
        idle(R + 3);

        // Start held high: back-to-back operations every R+2 edges.
        for (int i = 0; i < 4 * (R + 2); i++) cycle(1'b1, 4'h0, 4'h1);
        idle(R + 3);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 3) == 0, 4'($urandom), 4'($urandom));
        idle(R + 3);

        // Reset during round 1 aborts the operation, then recovery.
        cycle(1'b1, 4'h7, 4'hC);
        idle(2);
        #2;
        do_reset();
        cycle(1'b1, 4'h0, 4'h1);
        idle(R + 3);
        check("drained", exp_q.size(), 0);

        // Duplicate mismatch in round 2: terminal alarm, starts ignored.
        cycle(1'b1, 4'h3, 4'h9);
        inj_edge   = op_t + 2;
        alarm_edge = op_t + 2;
        exp_q.delete();
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'($urandom), 4'($urandom));
        idle(2);
        do_reset();
        cycle(1'b1, 4'h0, 4'h1);
        idle(R + 3);
        check("drained_end", exp_q.size(), 0);

        // ROUNDS=1 instance: 3/6 -> 5, then random operands.
        for (int i = 0; i < 6; i++) begin
            s = (i == 0) ? 4'h3 : 4'($urandom);
            k = (i == 0) ? 4'h6 : 4'($urandom);
            res = after(s, k, 1);
            @(negedge clock);
            b_start    = 1'b1;
            b_state_in = s;
            b_key_in   = k;
            @(negedge clock);
            b_start = 1'b0;
            check("r1_busy_round", b_busy, 1);
            check("r1_done_early", b_done, 0);
            @(negedge clock);
            check("r1_done", b_done, 1);
            check("r1_busy_done", b_busy, 1);
            check("r1_out", b_out, res[7:4]);
            @(negedge clock);
            check("r1_done_pulse", b_done, 0);
            check("r1_busy_idle", b_busy, 0);
            check("r1_out_hold", b_out, res[7:4]);
            check("r1_fault", b_fault, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
